tb_cheshire_cfg_responder: RTL and testbench
============================================

Name: tb_cheshire_cfg_responder

Overview:
- Simulation-side register responder that exposes the numerically selected Cheshire test configuration to software running on the SoC.
- Also provides an end-of-computation (EOC) mailbox and a free-running cycle counter.
- Sits on a single-outstanding valid/ready request/response port, driven by the SoC's testbench-facing register interface.
- The bench reads the config index and feature flags and watches eoc_o/exit_code_o to finish simulation.

Parameters:
- CfgIdx, 0, index into the package's config array (0 default, 1 RT, 2 CLIC, 3 vCLIC); must be < NumCheshireConfigs
- AddrWidth, 8, byte-address width of the request port
- Magic, 32'hC4E5_0CF6, constant returned at offset 0x00

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_addr_i  in  AddrWidth  byte address
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  read data (0 on writes/errors)
- rsp_error_o  out  1  decode/access error
- eoc_o  out  1  end of computation, sticky
- exit_code_o  out  31  exit code latched with eoc_o

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-low (rst_ni).
- Reset values (sampled on clk_i while rst_ni=0): rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, eoc_o=0, exit_code_o=0, cycle counter=0.
- Handshake:
  - req_ready_o = !rsp_valid_q || rsp_ready_i (combinational).
  - A request accepted in cycle N gives rsp_valid_o=1 in cycle N+1.
  - Response is held stable until rsp_ready_i. Back-to-back requests sustain one per cycle.
- Register map (word offsets); req_addr_i[1:0]!=0 -> error:
  - 0x00 RO Magic.
  - 0x04 RO CfgIdx.
  - 0x08 RO flags: bit0 AxiRt, bit1 Clic, bit2 ClicVsclic, bit3 ClicVsprio; others 0.
  - 0x0C RO ClicNumVsctxts in [7:0]; ClicPrioWidth in [15:8].
  - 0x10 RW EOC:
    - A write with wstrb=4'hF and wdata[0]=1 sets eoc_o=1 and exit_code_o=wdata[31:1].
    - A write with wdata[0]=0 is accepted but has no effect.
    - Read returns {exit_code_o, eoc_o}.
  - 0x14 RO cycle counter [31:0]. Reading it snapshots [63:32] into a shadow register.
  - 0x18 RO shadow high word (coherent 64-bit read = 0x14 then 0x18).
- Errors: write to any RO register, partial-strobe write to 0x10, or unmapped address -> rsp_error_o=1, rdata=0, no state change.
- EOC is sticky: once eoc_o=1, further EOC writes get an OKAY response but are ignored. Only reset clears it.
- Cycle counter:
  - 64-bit, increments every cycle after reset release and wraps 2^64-1 -> 0.
  - It keeps counting after EOC.
- Simultaneous rsp_ready_i and new req_valid_i: the old response retires and the new one loads in the same edge.
- Reset mid-transaction: a pending response is dropped, with rsp_valid_o=0 the next cycle.
- Response FSM:
  - IDLE -> RESP on accept.
  - RESP -> RESP on ready&&new accept.
  - RESP -> IDLE on ready without a new request.

Decomposition:
- Shared package (tb_cheshire_pkg):
  - register offset localparams
  - flag bit positions
  - Magic
  - rsp struct type {rdata, error}
- Config fields come from TbCheshireConfigs[CfgIdx]; the block adds no new config generator.
- One sub-module: tb_cheshire_cycle_counter (64-bit counter plus snapshot shadow).

Test Plan:
- CfgIdx=3; read 0x08 and 0x0C -> 0x0000000E and ClicNumVsctxts=4 / ClicPrioWidth=1 in the respective fields; read 0x00 -> 0xC4E50CF6, error=0.
- Write 0x10 wdata=0x0000002B, wstrb=F -> eoc_o=1 next cycle, exit_code_o=21; then write 0x10 wdata=0x3 -> eoc_o stays 1, exit_code_o stays 21, error=0.
- Write 0x08, read 0x20, and read address 0x05 -> rsp_error_o=1, rdata=0; partial-strobe write wstrb=4'h1 to 0x10 -> error=1, eoc_o stays 0.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_valid_o and rdata stable and req_ready_o=0; then stream 8 back-to-back reads with rsp_ready_i=1 -> 8 responses in 8 consecutive cycles.
- Force counter to 0x0000_0000_FFFF_FFFE; read 0x14 then 0x18 two cycles later -> low word 0xFFFFFFFF (read issued at the 0xFFFFFFFF value), high word 0; a later read pair reflects the wrapped low word and high word 1.
- Assert rst_ni=0 while rsp_valid_o=1 and eoc_o=1 -> next cycle rsp_valid_o=0, eoc_o=0, counter=0.

Source files
------------

// File: rtl/tb_cheshire_pkg.sv
// Shared definitions for the Cheshire test-configuration responder: register
// offsets, flag bit positions, the magic word, the response record and the
// table of selectable test configurations.
package tb_cheshire_pkg;

  localparam int unsigned NumCheshireConfigs = 4;

  // Register byte offsets.
  localparam int unsigned RegMagic       = 'h00;
  localparam int unsigned RegCfgIdx      = 'h04;
  localparam int unsigned RegFlags       = 'h08;
  localparam int unsigned RegClic        = 'h0C;
  localparam int unsigned RegEoc         = 'h10;
  localparam int unsigned RegCycleLo     = 'h14;
  localparam int unsigned RegCycleShadow = 'h18;

  // Bit positions inside the flags register.
  localparam int unsigned FlagAxiRt      = 0;
  localparam int unsigned FlagClic       = 1;
  localparam int unsigned FlagClicVsclic = 2;
  localparam int unsigned FlagClicVsprio = 3;

  localparam logic [31:0] TbCheshireMagic = 32'hC4E5_0CF6;

  typedef struct packed {
    logic       axi_rt;
    logic       clic;
    logic       clic_vsclic;
    logic       clic_vsprio;
    logic [7:0] clic_num_vsctxts;
    logic [7:0] clic_prio_width;
  } cheshire_cfg_t;

  // 0 default, 1 RT, 2 CLIC, 3 vCLIC.
  localparam cheshire_cfg_t TbCheshireConfigs [NumCheshireConfigs] = '{
    '{axi_rt: 1'b0, clic: 1'b0, clic_vsclic: 1'b0, clic_vsprio: 1'b0,
      clic_num_vsctxts: 8'd0, clic_prio_width: 8'd0},
    '{axi_rt: 1'b1, clic: 1'b0, clic_vsclic: 1'b0, clic_vsprio: 1'b0,
      clic_num_vsctxts: 8'd0, clic_prio_width: 8'd0},
    '{axi_rt: 1'b0, clic: 1'b1, clic_vsclic: 1'b0, clic_vsprio: 1'b0,
      clic_num_vsctxts: 8'd0, clic_prio_width: 8'd8},
    '{axi_rt: 1'b0, clic: 1'b1, clic_vsclic: 1'b1, clic_vsprio: 1'b1,
      clic_num_vsctxts: 8'd4, clic_prio_width: 8'd1}
  };

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  typedef enum logic {
    RspIdle = 1'b0,
    RspResp = 1'b1
  } rsp_state_e;

  // Pack the boolean feature switches of a configuration into the flags word.
  function automatic logic [31:0] cfg_flags(cheshire_cfg_t cfg);
    logic [31:0] flags;
    flags                 = '0;
    flags[FlagAxiRt]      = cfg.axi_rt;
    flags[FlagClic]       = cfg.clic;
    flags[FlagClicVsclic] = cfg.clic_vsclic;
    flags[FlagClicVsprio] = cfg.clic_vsprio;
    return flags;
  endfunction

endpackage

// File: rtl/tb_cheshire_cfg_responder_if.sv
// Single-outstanding valid/ready request/response register port.
interface tb_cheshire_cfg_responder_if #(
  parameter int unsigned AddrWidth = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 req_write;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_error;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/tb_cheshire_cycle_counter.sv
// Free-running 64-bit cycle counter with a high-word shadow captured whenever
// the low word is read, so a low-then-high read pair is coherent.
module tb_cheshire_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        snapshot_i,
  output logic [31:0] low_o,
  output logic [31:0] shadow_o
);

  logic [63:0] cnt_q;
  logic [31:0] shadow_q;

  // Count every cycle out of reset; capture the high word on a low-word read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (snapshot_i) shadow_q <= cnt_q[63:32];
    end
  end

  assign low_o    = cnt_q[31:0];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/tb_cheshire_cfg_responder.sv
// Register responder exposing the selected Cheshire test configuration, an
// end-of-computation mailbox and a 64-bit cycle counter.
module tb_cheshire_cfg_responder
  import tb_cheshire_pkg::*;
#(
  parameter int unsigned CfgIdx    = 0,
  parameter int unsigned AddrWidth = 8,
  parameter logic [31:0] Magic     = TbCheshireMagic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  tb_cheshire_cfg_responder_if.slave   bus,
  output logic                         eoc_o,
  output logic [30:0]                  exit_code_o
);

  localparam cheshire_cfg_t Cfg = TbCheshireConfigs[CfgIdx];

  rsp_state_e  state_q, state_d;
  rsp_t        rsp_q, rsp_d;
  logic        eoc_q;
  logic [30:0] exit_code_q;
  logic        accept;
  logic        eoc_set;
  logic        snapshot;
  logic [31:0] cnt_low;
  logic [31:0] cnt_shadow;

  tb_cheshire_cycle_counter u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .snapshot_i (snapshot),
    .low_o      (cnt_low),
    .shadow_o   (cnt_shadow)
  );

  assign accept = bus.req_valid && bus.req_ready;

  // Decode the presented request into its response and side effects.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    rsp_d    = '{rdata: 32'h0, error: 1'b0};
    eoc_set  = 1'b0;
    snapshot = 1'b0;
    if (bus.req_addr[1:0] != 2'b00) begin
      rsp_d.error = 1'b1;
    end else if (bus.req_write) begin
      // Only the EOC mailbox is writable, and only as a full word.
      if (bus.req_addr == AddrWidth'(RegEoc) && bus.req_wstrb == 4'hF) begin
        eoc_set = accept && bus.req_wdata[0] && !eoc_q;
      end else begin
        rsp_d.error = 1'b1;
      end
    end else begin
      case (bus.req_addr)
        AddrWidth'(RegMagic):       rsp_d.rdata = Magic;
        AddrWidth'(RegCfgIdx):      rsp_d.rdata = 32'(CfgIdx);
        AddrWidth'(RegFlags):       rsp_d.rdata = cfg_flags(Cfg);
        AddrWidth'(RegClic):        rsp_d.rdata = {16'h0, Cfg.clic_prio_width,
                                                   Cfg.clic_num_vsctxts};
        AddrWidth'(RegEoc):         rsp_d.rdata = {exit_code_q, eoc_q};
        AddrWidth'(RegCycleLo): begin
          rsp_d.rdata = cnt_low;
          snapshot    = accept;
        end
        AddrWidth'(RegCycleShadow): rsp_d.rdata = cnt_shadow;
        default:                    rsp_d.error = 1'b1;
      endcase
    end
  end

  // Response FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= RspIdle;
    else         state_q <= state_d;
  end

  // Response FSM next state: stay busy while responses keep being replaced.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RspIdle: if (accept) state_d = RspResp;
      RspResp: if (bus.rsp_ready && !accept) state_d = RspIdle;
      default: state_d = RspIdle;
    endcase
  end

  // Response FSM outputs: a new request is taken when the slot is free or
  // being freed in the same cycle.
  always_comb begin
    bus.rsp_valid = (state_q == RspResp);
    bus.req_ready = (state_q != RspResp) || bus.rsp_ready;
    bus.rsp_rdata = rsp_q.rdata;
    bus.rsp_error = rsp_q.error;
  end

  // Response payload and sticky EOC mailbox.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_q       <= '0;
      eoc_q       <= 1'b0;
      exit_code_q <= '0;
    end else begin
      if (accept) rsp_q <= rsp_d;
      if (eoc_set) begin
        eoc_q       <= 1'b1;
        exit_code_q <= bus.req_wdata[31:1];
      end
    end
  end

  assign eoc_o       = eoc_q;
  assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_tb_cheshire_cfg_responder.sv
// Directed bench for the Cheshire config responder instantiated with the vCLIC
// configuration: register table, stall/stream handshake, counter wrap and
// reset during a pending response.
module tb_tb_cheshire_cfg_responder;

  localparam logic [31:0] MagicWord = 32'hC4E5_0CF6;

  logic        clk;
  logic        rst_n;
  logic        eoc;
  logic [30:0] exit_code;
  int          n_tests;
  int          n_fail;

  tb_cheshire_cfg_responder_if #(.AddrWidth(8)) bus ();

  tb_cheshire_cfg_responder #(
    .CfgIdx    (3),
    .AddrWidth (8),
    .Magic     (MagicWord)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .eoc_o       (eoc),
    .exit_code_o (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_error;
    logic        exp_eoc;
    logic [30:0] exp_exit;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request, wait (bounded) for acceptance, then check the response.
  task automatic run_vec(input vec_t v, input int idx);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wstrb = v.wstrb;
    #1;
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check($sformatf("vec%0d_ready", idx), bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("vec%0d_valid", idx), bus.rsp_valid, 1);
    check($sformatf("vec%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("vec%0d_error", idx), bus.rsp_error, v.exp_error);
    check($sformatf("vec%0d_eoc", idx), eoc, v.exp_eoc);
    check($sformatf("vec%0d_exit", idx), exit_code, v.exp_exit);
  endtask

  task automatic drive_read(input logic [7:0] addr);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
  endtask

  logic [7:0]  stream_addr [8];
  logic [31:0] stream_exp  [8];

  initial begin
    //           write  addr   wdata         wstrb  rdata          err   eoc   exit
    vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, MagicWord,     1'b0, 1'b0, 31'd0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'd3,         1'b0, 1'b0, 31'd0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h0000_000E, 1'b0, 1'b0, 31'd0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0000_0104, 1'b0, 1'b0, 31'd0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0,         1'b0, 1'b0, 31'd0};
    vecs[5]  = '{1'b1, 8'h08, 32'h1,        4'hF, 32'h0,         1'b1, 1'b0, 31'd0};
    vecs[6]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h0,         1'b1, 1'b0, 31'd0};
    vecs[7]  = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h0,         1'b1, 1'b0, 31'd0};
    vecs[8]  = '{1'b1, 8'h10, 32'h0000_002B, 4'h1, 32'h0,        1'b1, 1'b0, 31'd0};
    vecs[9]  = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'h0,         1'b1, 1'b0, 31'd0};
    vecs[10] = '{1'b1, 8'h14, 32'h5,        4'hF, 32'h0,         1'b1, 1'b0, 31'd0};
    vecs[11] = '{1'b1, 8'h10, 32'h0000_002A, 4'hF, 32'h0,        1'b0, 1'b0, 31'd0};
    vecs[12] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0,         1'b0, 1'b0, 31'd0};
    vecs[13] = '{1'b1, 8'h10, 32'h0000_002B, 4'hF, 32'h0,        1'b0, 1'b1, 31'd21};
    vecs[14] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0000_002B, 1'b0, 1'b1, 31'd21};
    vecs[15] = '{1'b1, 8'h10, 32'h0000_0003, 4'hF, 32'h0,        1'b0, 1'b1, 31'd21};
    vecs[16] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0000_002B, 1'b0, 1'b1, 31'd21};
    vecs[17] = '{1'b0, 8'h18, 32'h0,        4'h0, 32'h0,         1'b0, 1'b1, 31'd21};
    vecs[18] = '{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,         1'b1, 1'b1, 31'd21};

    stream_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h08, 8'h04, 8'h00};
    stream_exp  = '{MagicWord, 32'd3, 32'hE, 32'h104, 32'h2B, 32'hE, 32'd3, MagicWord};

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_error", bus.rsp_error, 0);
    check("rst_eoc", eoc, 0);
    check("rst_exit", exit_code, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_cnt", dut.u_counter.cnt_q, 64'd0);

    // First request on the release edge reads the counter at zero.
    rst_n = 1'b1;
    drive_read(8'h14);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("first_cnt_valid", bus.rsp_valid, 1);
    check("first_cnt_rdata", bus.rsp_rdata, 0);

    // Register map, errors and EOC mailbox.
    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // Stall: response must hold while rsp_ready is low, with a request waiting.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_read(8'h00);
    @(negedge clk);
    drive_read(8'h04);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), bus.rsp_valid, 1);
      check($sformatf("stall%0d_rdata", i), bus.rsp_rdata, MagicWord);
      check($sformatf("stall%0d_ready", i), bus.req_ready, 0);
      @(negedge clk);
    end
    // Retire and reload on the same edge.
    bus.rsp_ready = 1'b1;
    #1;
    check("retire_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("reload_valid", bus.rsp_valid, 1);
    check("reload_rdata", bus.rsp_rdata, 32'd3);
    @(negedge clk);
    check("reload_idle", bus.rsp_valid, 0);

    // Eight back-to-back reads give eight responses in consecutive cycles.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("stream%0d_valid", k - 1), bus.rsp_valid, 1);
        check($sformatf("stream%0d_rdata", k - 1), bus.rsp_rdata, stream_exp[k-1]);
      end
      if (k < 8) drive_read(stream_addr[k]);
      else       bus.req_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_idle", bus.rsp_valid, 0);

    // Counter wrap of the low word and coherent high-word shadow.
    dut.u_counter.cnt_q = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    drive_read(8'h14);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("wrap_lo_rdata", bus.rsp_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    drive_read(8'h18);
    @(negedge clk);
    check("wrap_hi_rdata", bus.rsp_rdata, 32'h0);
    drive_read(8'h14);
    @(negedge clk);
    check("wrap2_lo_rdata", bus.rsp_rdata, 32'h2);
    drive_read(8'h18);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("wrap2_hi_rdata", bus.rsp_rdata, 32'h1);
    check("wrap2_error", bus.rsp_error, 0);

    // Reset while a response is pending and EOC is set.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_read(8'h00);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_rst_valid", bus.rsp_valid, 1);
    check("pre_rst_eoc", eoc, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_eoc", eoc, 0);
    check("mid_rst_exit", exit_code, 0);
    check("mid_rst_rdata", bus.rsp_rdata, 0);
    check("mid_rst_cnt", dut.u_counter.cnt_q, 64'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
